// File: rtl/inst_mem_loader.sv
// Instruction RAM with a byte-serial program loader and a registered CPU fetch port.
// Latency: fetch data appears 1 cycle after read_inst_enable; a completed word is written on the edge of its last byte.
// Backpressure: load_ready is high only in LOAD; the CPU is held (cpu_run=0) until the download finishes.
module inst_mem_loader #(
    parameter int WIDTH_DATA = 32,
    parameter int AWIDTH     = 5,
    parameter int DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  load_end,
    input  logic                  load_valid,
    input  logic [7:0]            load_data,
    output logic                  load_ready,
    input  logic [AWIDTH-1:0]     address_memory_inst,
    input  logic                  read_inst_enable,
    output logic [WIDTH_DATA-1:0] instruction,
    output logic                  cpu_run,
    output logic [AWIDTH:0]       words_loaded,
    output logic                  load_error
);

    localparam int BYTES = WIDTH_DATA / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [BCW-1:0]        r_byte_cnt;
    logic [AWIDTH-1:0]     r_wr_ptr;
    logic [AWIDTH:0]       r_words;
    logic                  r_error;
    logic [WIDTH_DATA-1:0] r_asm;
    logic [WIDTH_DATA-1:0] r_instr;
    logic [WIDTH_DATA-1:0] r_mem [DEPTH];

    logic                  w_accept;
    logic                  w_last;
    logic                  w_word_done;
    logic                  w_full;
    logic                  w_fetch_ok;
    logic [WIDTH_DATA-1:0] w_word;

    // A restart pulse takes priority, so a byte presented alongside load_start is dropped.
    assign w_accept    = (r_state == S_LOAD) && load_valid && !load_start;
    assign w_last      = (r_byte_cnt == BCW'(BYTES - 1));
    assign w_word_done = w_accept && w_last;
    assign w_full      = w_word_done && (r_words == (AWIDTH + 1)'(DEPTH - 1));
    // Big-endian assembly: earlier bytes move toward the MSB as new ones arrive.
    assign w_word      = WIDTH_DATA'({r_asm, load_data});
    assign w_fetch_ok  = ({1'b0, address_memory_inst} < (AWIDTH + 1)'(DEPTH));

    assign load_ready   = (r_state == S_LOAD);
    assign cpu_run      = (r_state == S_RUN);
    assign words_loaded = r_words;
    assign load_error   = r_error;
    assign instruction  = r_instr;

    // Next-state selection: start always (re)enters LOAD; LOAD leaves on a full RAM or load_end.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (load_start) w_next = S_LOAD;
            S_LOAD: begin
                if (load_start)                w_next = S_LOAD;
                else if (w_full || load_end)   w_next = S_RUN;
            end
            S_RUN:  if (load_start) w_next = S_LOAD;
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Loader bookkeeping: byte counter, write pointer, word count and partial-word flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_byte_cnt <= '0;
            r_wr_ptr   <= '0;
            r_words    <= '0;
            r_error    <= 1'b0;
            r_asm      <= '0;
        end else if (load_start) begin
            r_byte_cnt <= '0;
            r_wr_ptr   <= '0;
            r_words    <= '0;
            r_error    <= 1'b0;
        end else if (r_state == S_LOAD) begin
            if (w_accept) begin
                r_asm <= w_word;
                if (w_last) begin
                    r_byte_cnt <= '0;
                    r_wr_ptr   <= r_wr_ptr + 1'b1;
                    r_words    <= r_words + 1'b1;
                end else begin
                    r_byte_cnt <= r_byte_cnt + 1'b1;
                end
            end
            // Ending mid-word drops the partial bytes; a word completing on this edge is not partial.
            if (load_end && !w_full) begin
                r_byte_cnt <= '0;
                r_error    <= (r_byte_cnt != '0) && !w_word_done;
            end
        end
    end

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (reset && w_word_done) r_mem[r_wr_ptr] <= w_word;
    end

    // Fetch port: only live in RUN, zero otherwise; out-of-range addresses read as zero.
    always_ff @(posedge clk) begin
        if (!reset || (r_state != S_RUN)) begin
            r_instr <= '0;
        end else if (read_inst_enable) begin
            r_instr <= w_fetch_ok ? r_mem[address_memory_inst] : '0;
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: directed downloads, fetches checked by a separate monitor.
// Fetch expectations are queued at issue time and popped when the DUT's 1-cycle fetch result appears.
// Status outputs are checked directly by the stimulus process after each cycle.
module tb_inst_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic        load_end;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_ready;
    logic [4:0]  address_memory_inst;
    logic        read_inst_enable;
    logic [31:0] instruction;
    logic        cpu_run;
    logic [5:0]  words_loaded;
    logic        load_error;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    inst_mem_loader #(.WIDTH_DATA(32), .AWIDTH(5), .DEPTH(32)) dut (
        .clk                 (clk),
        .reset               (reset),
        .load_start          (load_start),
        .load_end            (load_end),
        .load_valid          (load_valid),
        .load_data           (load_data),
        .load_ready          (load_ready),
        .address_memory_inst (address_memory_inst),
        .read_inst_enable    (read_inst_enable),
        .instruction         (instruction),
        .cpu_run             (cpu_run),
        .words_loaded        (words_loaded),
        .load_error          (load_error)
    );

    always #5 clk = ~clk;

    // Monitor: a strobe seen in RUN at an edge means instruction is valid just after it.
    always @(posedge clk) begin
        logic en;
        en = read_inst_enable && cpu_run;
        #1;
        if (en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL fetch_unexpected: instruction=%08h with no expected value queued", instruction);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (instruction !== e) begin
                    errors++;
                    $display("FAIL fetch: got %08h expected %08h", instruction, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        load_valid = 1'b1;
        load_data  = b;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic pulse_end();
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
    endtask

    task automatic fetch(input logic [4:0] a, input logic [31:0] e);
        exp_q.push_back(e);
        address_memory_inst = a;
        read_inst_enable    = 1'b1;
        tick();
        read_inst_enable    = 1'b0;
    endtask

    task automatic chk_status(input string tag, input logic run, input logic rdy,
                              input logic [5:0] words, input logic err);
        chk({tag, "_cpu_run"}, {31'd0, cpu_run}, {31'd0, run});
        chk({tag, "_load_ready"}, {31'd0, load_ready}, {31'd0, rdy});
        chk({tag, "_words_loaded"}, {26'd0, words_loaded}, {26'd0, words});
        chk({tag, "_load_error"}, {31'd0, load_error}, {31'd0, err});
    endtask

    initial begin
        logic [7:0] prog [8];
        logic [31:0] held;
        prog = '{8'h08, 8'h00, 8'h00, 8'h05, 8'h20, 8'h00, 8'h00, 8'h00};

        reset = 1'b0; load_start = 1'b0; load_end = 1'b0;
        load_valid = 1'b1; load_data = 8'h5A;
        address_memory_inst = '0; read_inst_enable = 1'b0;

        // Reset held two cycles with valid asserted.
        tick(); tick();
        chk("reset_instruction", instruction, 32'h0);
        chk_status("reset", 1'b0, 1'b0, 6'd0, 1'b0);
        reset = 1'b1; load_valid = 1'b0;
        tick();
        chk_status("idle", 1'b0, 1'b0, 6'd0, 1'b0);

        // Two-word back-to-back download.
        pulse_start();
        chk_status("load_entry", 1'b0, 1'b1, 6'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            load_valid = 1'b1; load_data = prog[i]; tick();
        end
        load_valid = 1'b0;
        pulse_end();
        chk_status("two_word", 1'b1, 1'b0, 6'd2, 1'b0);
        fetch(5'd0, 32'h0800_0005);
        fetch(5'd1, 32'h2000_0000);
        held = 32'h2000_0000;
        tick(); tick();
        chk("instruction_hold", instruction, held);

        // Same program with valid gapped; data stays on the bus during gaps.
        pulse_start();
        chk_status("regap_entry", 1'b0, 1'b1, 6'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send_byte(prog[i]);
            tick();
        end
        pulse_end();
        chk_status("gapped", 1'b1, 1'b0, 6'd2, 1'b0);
        fetch(5'd0, 32'h0800_0005);
        fetch(5'd1, 32'h2000_0000);

        // Full RAM: 128 bytes, word n = n, valid kept high afterwards.
        pulse_start();
        for (int i = 0; i < 128; i++) begin
            load_valid = 1'b1;
            load_data  = ((i % 4) == 3) ? 8'(i / 4) : 8'h00;
            tick();
            if (i == 126) chk_status("full_before_last", 1'b0, 1'b1, 6'd31, 1'b0);
        end
        load_data = 8'hFF;
        chk_status("full_done", 1'b1, 1'b0, 6'd32, 1'b0);
        tick(); tick(); tick();
        chk_status("full_hold", 1'b1, 1'b0, 6'd32, 1'b0);
        load_valid = 1'b0;
        fetch(5'd31, 32'h0000_001F);
        fetch(5'd0,  32'h0000_0000);
        fetch(5'd17, 32'h0000_0011);

        // Partial word, then a stray load_end in RUN.
        pulse_start();
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        pulse_end();
        chk_status("partial", 1'b1, 1'b0, 6'd0, 1'b1);
        pulse_end();
        chk_status("end_in_run", 1'b1, 1'b0, 6'd0, 1'b1);

        // load_end coincident with the final byte of a word.
        pulse_start();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        load_valid = 1'b1; load_data = 8'h44; load_end = 1'b1;
        tick();
        load_valid = 1'b0; load_end = 1'b0;
        chk_status("end_with_last", 1'b1, 1'b0, 6'd1, 1'b0);
        fetch(5'd0, 32'h1122_3344);

        // Restart mid-word; the byte alongside load_start must be ignored.
        pulse_start();
        address_memory_inst = 5'd0; read_inst_enable = 1'b1;
        send_byte(8'h01);
        read_inst_enable = 1'b0;
        chk("fetch_in_load", instruction, 32'h0);
        send_byte(8'h02);
        load_start = 1'b1; load_valid = 1'b1; load_data = 8'h99;
        tick();
        load_start = 1'b0; load_valid = 1'b0;
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        pulse_end();
        chk_status("restart", 1'b1, 1'b0, 6'd1, 1'b0);
        fetch(5'd0, 32'h5566_7788);

        // Reset in the middle of a download; RAM must be retained.
        pulse_start();
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        send_byte(8'h12); send_byte(8'h34);
        chk_status("pre_reset", 1'b0, 1'b1, 6'd1, 1'b0);
        reset = 1'b0;
        tick();
        chk_status("mid_reset", 1'b0, 1'b0, 6'd0, 1'b0);
        reset = 1'b1;
        tick();
        chk_status("post_reset_idle", 1'b0, 1'b0, 6'd0, 1'b0);
        pulse_start();
        pulse_end();
        chk_status("empty_load", 1'b1, 1'b0, 6'd0, 1'b0);
        fetch(5'd0, 32'hDEAD_BEEF);
        fetch(5'd1, 32'h0000_0001);

        tick(); tick();
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Upstream neighbour of the stack CPU's fetch path. Owns the instruction RAM and serves the CPU's `address_memory_inst` / `read_inst_enable` / `instruction` interface.
- Also accepts a byte-serial program download. While a download is in progress it holds the CPU stopped via `cpu_run`, then releases it.
- Bytes assemble big-endian into WIDTH_DATA-bit words, so the opcode byte (bits 31:24) arrives first.

Parameters:
- WIDTH_DATA, 32, instruction word width; must be a multiple of 8.
- AWIDTH, 5, instruction address width.
- DEPTH, 32, number of instruction words; must be ≤ 2**AWIDTH.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- load_start  in  1  one-cycle pulse; begins or restarts a download.
- load_end  in  1  one-cycle pulse; ends a download early.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  8  program byte.
- load_ready  out  1  loader accepts a byte this cycle.
- address_memory_inst  in  AWIDTH  CPU fetch address.
- read_inst_enable  in  1  CPU fetch strobe.
- instruction  out  WIDTH_DATA  fetched word, registered.
- cpu_run  out  1  1 = CPU may execute; 0 = CPU must hold in reset.
- words_loaded  out  AWIDTH+1  complete words written by the last download.
- load_error  out  1  last download ended on a partial word.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; instruction=0, cpu_run=0, load_ready=0, words_loaded=0, load_error=0.
  - Byte counter and write pointer cleared.
  - RAM contents are NOT cleared.
- States:
  - IDLE: cpu_run=0, load_ready=0. load_start -> LOAD.
  - LOAD: cpu_run=0, load_ready=1.
    - Byte accepted iff load_valid && load_ready.
    - Bytes shift into an assembly register MSB-first.
    - On the 4th accepted byte, the word is written to RAM[wr_ptr] that same edge; wr_ptr and words_loaded increment.
    - When words_loaded reaches DEPTH -> RUN automatically. load_ready is 0 from the next cycle, and no further bytes are accepted.
    - load_end -> RUN.
  - RUN: cpu_run=1, load_ready=0. load_start -> LOAD.
- Entering LOAD:
  - Clears byte counter, wr_ptr, words_loaded and load_error.
  - Does not alter RAM.
- load_end with a nonzero byte count: the partial word is discarded, load_error=1, and words_loaded excludes it.
- load_end on the same cycle as the 4th byte of a word: the word is written, load_error=0, -> RUN.
- load_start in LOAD: the download restarts and any byte presented that cycle is ignored. load_start wins over load_end and load_valid.
- load_start / load_end in an inapplicable state: ignored (load_end in IDLE/RUN, load_start never lost).
- Fetch:
  - In RUN, read_inst_enable==1 at an edge loads instruction <= RAM[address_memory_inst]. Valid one cycle after the strobe (1-cycle latency).
  - Otherwise instruction holds its value.
  - In IDLE/LOAD, instruction is forced to 0 and strobes are ignored.
- Fetch addresses ≥ DEPTH return 0.
- Locations beyond words_loaded return whatever the RAM holds. The CPU program is responsible for staying in range.
- Reset mid-download: -> IDLE immediately. Words already written stay in RAM, but words_loaded=0.

Test Plan:
- Reset: drive reset=0 for 2 cycles with load_valid=1 -> instruction=0, cpu_run=0, load_ready=0, words_loaded=0, load_error=0.
- Two-word load:
  - Stimulus: load_start; bytes 08 00 00 05 20 00 00 00; load_end.
  - Required: words_loaded=2, load_error=0, cpu_run=1 the cycle after load_end.
  - Fetch addr 0 -> instruction=0x08000005 one cycle later. Fetch addr 1 -> 0x20000000.
- Gapped valid: same 8 bytes with load_valid deasserted on alternate cycles -> identical RAM contents and words_loaded=2; no byte duplicated.
- Full load:
  - Stimulus: 128 bytes (word n = n), with load_valid held high afterwards.
  - Required: automatic -> RUN; load_ready=0 after the final byte; words_loaded=32.
  - Fetch addr 31 -> 0x0000001F.
- Partial word: load_start; bytes AA BB CC; load_end -> load_error=1, words_loaded=0, cpu_run=1.
- Reset mid-load:
  - Stimulus: load 1 word DEADBEEF plus 2 bytes, then reset=0.
  - Required: IDLE, cpu_run=0, words_loaded=0.
  - Follow-up: load_start then immediate load_end, then fetch addr 0 -> 0xDEADBEEF, showing the RAM was retained.
